line_burst_adaptor: RTL and testbench

LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

---
 rtl/line_burst_adaptor_if.sv | 27 ++
 rtl/line_burst_adaptor.sv | 103 ++++++++++
 tb/tb_line_burst_adaptor.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_burst_adaptor_if.sv
// Line-side and burst-side signal bundle for line_burst_adaptor.
// slave is the adaptor's view; master is the requester plus memory environment.
interface line_burst_adaptor_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;

    logic         burst_read;
    logic         burst_write;
    logic [31:0]  burst_address;
    logic [63:0]  burst_wdata;
    logic [63:0]  burst_rdata;
    logic         burst_resp;

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
        output pmem_resp, pmem_rdata, burst_read, burst_write, burst_address, burst_wdata
    );

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata, burst_rdata, burst_resp,
        input  pmem_resp, pmem_rdata, burst_read, burst_write, burst_address, burst_wdata
    );
endinterface

// File: rtl/line_burst_adaptor.sv
// Converts 256-bit line reads/writes into four 64-bit bursts, beat 0 = line bits 63:0.
// Define LINE_BURST_ADAPTOR_ALIGN_EN to force burst_address[4:0] to zero.
module line_burst_adaptor (
    input logic                  clk,
    input logic                  rst,
    line_burst_adaptor_if.slave  bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRead  = 2'd1;
    localparam logic [1:0] StWrite = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [31:0]  addr_q, addr_d;
    logic [255:0] wline_q, wline_d;
    logic [255:0] rline_q, rline_d;
    logic [7:0]   beat_lsb;

    assign beat_lsb = {beat_q, 6'd0};

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            StIdle: begin
                // A write wins over a simultaneous read.
                if (bus.pmem_write) begin
                    addr_d  = bus.pmem_address;
                    wline_d = bus.pmem_wdata;
                    beat_d  = 2'd0;
                    state_d = StWrite;
                end else if (bus.pmem_read) begin
                    addr_d  = bus.pmem_address;
                    beat_d  = 2'd0;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (bus.burst_resp) begin
                    rline_d[beat_lsb +: 64] = bus.burst_rdata;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StWrite: begin
                if (bus.burst_resp) begin
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Requests are deliberately not sampled here.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            beat_q  <= 2'd0;
            addr_q  <= 32'd0;
            wline_q <= 256'd0;
            rline_q <= 256'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    assign bus.pmem_resp   = (state_q == StDone);
    assign bus.pmem_rdata  = rline_q;
    assign bus.burst_read  = (state_q == StRead);
    assign bus.burst_write = (state_q == StWrite);
    assign bus.burst_wdata = (state_q == StWrite) ? wline_q[beat_lsb +: 64] : 64'd0;

`ifdef LINE_BURST_ADAPTOR_ALIGN_EN
    assign bus.burst_address = {addr_q[31:5], 5'd0};
`else
    assign bus.burst_address = addr_q;
`endif

    a_no_dual_burst: assert property (@(posedge clk) disable iff (rst)
        !(bus.burst_read && bus.burst_write));

    a_resp_single: assert property (@(posedge clk) disable iff (rst)
        bus.pmem_resp |=> !bus.pmem_resp);

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Randomized self-checking bench for line_burst_adaptor against a line-level model.
module tb_line_burst_adaptor;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [255:0] exp_rdata;

    line_burst_adaptor_if bus ();

    line_burst_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] exp_addr(input logic [31:0] a);
`ifdef LINE_BURST_ADAPTOR_ALIGN_EN
        return a & 32'hFFFF_FFE0;
`else
        return a;
`endif
    endfunction

    // Drives one line request plus four beats (gap idle cycles before each beat) and
    // reports what was observed; returns in the cycle after the pmem_resp cycle.
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] line, input int gap, input bit hold,
                           output logic br_seen, output logic bw_seen,
                           output logic [31:0] addr_seen, output logic stable,
                           output int resp_cycle, output logic [255:0] rdata_done,
                           output logic [255:0] wseq);
        int cyc;
        cyc        = 0;
        stable     = 1'b1;
        resp_cycle = -1;
        rdata_done = '0;
        wseq       = '0;
        bus.pmem_read    = rd;
        bus.pmem_write   = wr;
        bus.pmem_address = addr;
        bus.pmem_wdata   = line;
        tick(); cyc++;
        br_seen   = bus.burst_read;
        bw_seen   = bus.burst_write;
        addr_seen = bus.burst_address;
        if (!hold) begin
            bus.pmem_read    = 1'b0;
            bus.pmem_write   = 1'b0;
            bus.pmem_address = $urandom;
            bus.pmem_wdata   = rand256();
        end
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g <= gap; g++) begin
                if (bus.burst_read !== br_seen || bus.burst_write !== bw_seen ||
                    bus.burst_address !== addr_seen || bus.pmem_resp !== 1'b0)
                    stable = 1'b0;
                if (g < gap) begin
                    bus.burst_rdata = {$urandom, $urandom};
                    tick(); cyc++;
                end
            end
            wseq[64*k +: 64] = bus.burst_wdata;
            bus.burst_rdata  = line[64*k +: 64];
            bus.burst_resp   = 1'b1;
            tick(); cyc++;
            bus.burst_resp   = 1'b0;
            bus.burst_rdata  = {$urandom, $urandom};
        end
        for (int i = 0; i < 8 && resp_cycle < 0; i++) begin
            if (bus.pmem_resp === 1'b1) begin
                resp_cycle = cyc;
                rdata_done = bus.pmem_rdata;
            end else begin
                tick(); cyc++;
            end
        end
        // A stray beat during the response cycle must be ignored.
        bus.burst_resp  = 1'b1;
        bus.burst_rdata = {$urandom, $urandom};
        tick();
        bus.burst_resp  = 1'b0;
    endtask

    task automatic test_reset();
        bus.pmem_read    = 1'b1;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = 32'hDEAD_BEEF;
        bus.pmem_wdata   = rand256();
        bus.burst_rdata  = 64'd0;
        bus.burst_resp   = 1'b0;
        rst = 1'b1;
        tick(); tick();
        n_checks++; if (bus.pmem_resp !== 1'b0) begin n_fail++;
            $display("FAIL reset pmem_resp: got %b required 0", bus.pmem_resp); end
        n_checks++; if (bus.pmem_rdata !== 256'd0) begin n_fail++;
            $display("FAIL reset pmem_rdata: got %h required 0", bus.pmem_rdata); end
        n_checks++; if (bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin n_fail++;
            $display("FAIL reset burst_rw: got %b%b required 00", bus.burst_read,
                     bus.burst_write); end
        n_checks++; if (bus.burst_address !== 32'd0) begin n_fail++;
            $display("FAIL reset burst_address: got %h required 0", bus.burst_address); end
        n_checks++; if (bus.burst_wdata !== 64'd0) begin n_fail++;
            $display("FAIL reset burst_wdata: got %h required 0", bus.burst_wdata); end
        bus.pmem_read = 1'b0;
        rst = 1'b0;
        tick();
        exp_rdata = '0;
    endtask

    task automatic test_read_fixed();
        logic br, bw, st;
        logic [31:0] a;
        int rc;
        logic [255:0] rd, ws, line;
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        run_txn(1'b1, 1'b0, 32'h0000_2000, line, 0, 1'b0, br, bw, a, st, rc, rd, ws);
        n_checks++; if (rc !== 5) begin n_fail++;
            $display("FAIL read_fixed latency: got %0d required 5", rc); end
        n_checks++; if (rd !== line) begin n_fail++;
            $display("FAIL read_fixed rdata: got %h required %h", rd, line); end
        n_checks++; if (br !== 1'b1 || bw !== 1'b0 || st !== 1'b1) begin n_fail++;
            $display("FAIL read_fixed burst_rw: got %b%b stable %b required 10 stable 1",
                     br, bw, st); end
        exp_rdata = line;
        n_checks++; if (bus.pmem_resp !== 1'b0 || bus.pmem_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL read_fixed after: got resp %b rdata %h required 0 %h",
                     bus.pmem_resp, bus.pmem_rdata, exp_rdata); end
    endtask

    task automatic test_write_gaps();
        logic br, bw, st;
        logic [31:0] a;
        int rc;
        logic [255:0] rd, ws, line;
        line = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        run_txn(1'b0, 1'b1, 32'h0000_3000, line, 2, 1'b0, br, bw, a, st, rc, rd, ws);
        n_checks++; if (ws !== line) begin n_fail++;
            $display("FAIL write_gaps beat sequence: got %h required %h", ws, line); end
        n_checks++; if (rc !== 13) begin n_fail++;
            $display("FAIL write_gaps latency: got %0d required 13", rc); end
        n_checks++; if (bw !== 1'b1 || br !== 1'b0 || st !== 1'b1) begin n_fail++;
            $display("FAIL write_gaps burst_rw: got %b%b stable %b required 01 stable 1",
                     br, bw, st); end
        n_checks++; if (bus.pmem_resp !== 1'b0 || bus.burst_write !== 1'b0) begin n_fail++;
            $display("FAIL write_gaps single pulse: got resp %b bw %b required 0 0",
                     bus.pmem_resp, bus.burst_write); end
        n_checks++; if (bus.pmem_rdata !== exp_rdata) begin n_fail++;
            $display("FAIL write_gaps rdata hold: got %h required %h", bus.pmem_rdata,
                     exp_rdata); end
    endtask

    task automatic test_both();
        logic br, bw, st;
        logic [31:0] a;
        int rc;
        logic [255:0] rd, ws, line;
        line = rand256();
        run_txn(1'b1, 1'b1, 32'h0000_1040, line, 0, 1'b0, br, bw, a, st, rc, rd, ws);
        n_checks++; if (bw !== 1'b1 || br !== 1'b0) begin n_fail++;
            $display("FAIL both priority: got read %b write %b required 0 1", br, bw); end
        n_checks++; if (a !== 32'h0000_1040) begin n_fail++;
            $display("FAIL both address: got %h required 00001040", a); end
        n_checks++; if (ws !== line) begin n_fail++;
            $display("FAIL both wdata: got %h required %h", ws, line); end
    endtask

    task automatic test_align();
        logic br, bw, st;
        logic [31:0] a, want;
        int rc;
        logic [255:0] rd, ws, line;
`ifdef LINE_BURST_ADAPTOR_ALIGN_EN
        want = 32'h0000_1040;
`else
        want = 32'h0000_105C;
`endif
        line = rand256();
        run_txn(1'b1, 1'b0, 32'h0000_105C, line, 1, 1'b0, br, bw, a, st, rc, rd, ws);
        n_checks++; if (a !== want) begin n_fail++;
            $display("FAIL align address: got %h required %h", a, want); end
        n_checks++; if (rd !== line || rc !== 9) begin n_fail++;
            $display("FAIL align read: got %h at %0d required %h at 9", rd, rc, line); end
        exp_rdata = line;
    endtask

    task automatic test_reset_mid();
        logic br, bw, st;
        logic [31:0] a;
        int rc;
        logic [255:0] rd, ws, line;
        int resp_seen;
        bus.pmem_read    = 1'b1;
        bus.pmem_address = 32'h0000_4000;
        tick();
        bus.pmem_read = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            tick();
        end
        bus.burst_resp = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.burst_read !== 1'b0) begin n_fail++;
            $display("FAIL reset_mid burst_read: got %b required 0", bus.burst_read); end
        n_checks++; if (bus.pmem_rdata !== 256'd0) begin n_fail++;
            $display("FAIL reset_mid rdata: got %h required 0", bus.pmem_rdata); end
        resp_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.pmem_resp === 1'b1) resp_seen++;
            tick();
        end
        n_checks++; if (resp_seen !== 0) begin n_fail++;
            $display("FAIL reset_mid resp: got %0d pulses required 0", resp_seen); end
        exp_rdata = '0;
        line = rand256();
        run_txn(1'b1, 1'b0, 32'h0000_4100, line, 0, 1'b0, br, bw, a, st, rc, rd, ws);
        n_checks++; if (rd !== line || rc !== 5) begin n_fail++;
            $display("FAIL reset_mid next read: got %h at %0d required %h at 5", rd, rc,
                     line); end
        exp_rdata = line;
    endtask

    task automatic test_hold_read();
        logic br, bw, st;
        logic [31:0] a;
        int rc;
        logic [255:0] rd, ws, line, line2;
        line = rand256();
        run_txn(1'b1, 1'b0, 32'h0000_5000, line, 0, 1'b1, br, bw, a, st, rc, rd, ws);
        exp_rdata = line;
        n_checks++; if (rc !== 5 || rd !== line) begin n_fail++;
            $display("FAIL hold first: got %h at %0d required %h at 5", rd, rc, line); end
        n_checks++; if (bus.pmem_resp !== 1'b0 || bus.burst_read !== 1'b0) begin n_fail++;
            $display("FAIL hold after done: got resp %b read %b required 0 0",
                     bus.pmem_resp, bus.burst_read); end
        // Request still high in IDLE, so a fresh burst begins now.
        tick();
        bus.pmem_read = 1'b0;
        n_checks++; if (bus.burst_read !== 1'b1) begin n_fail++;
            $display("FAIL hold resample: got read %b required 1", bus.burst_read); end
        line2 = rand256();
        for (int k = 0; k < 4; k++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = line2[64*k +: 64];
            tick();
        end
        bus.burst_resp = 1'b0;
        n_checks++; if (bus.pmem_resp !== 1'b1 || bus.pmem_rdata !== line2) begin n_fail++;
            $display("FAIL hold second: got resp %b rdata %h required 1 %h", bus.pmem_resp,
                     bus.pmem_rdata, line2); end
        tick();
        exp_rdata = line2;
    endtask

    task automatic test_idle_resp();
        for (int i = 0; i < 4; i++) begin
            bus.burst_resp  = 1'b1;
            bus.burst_rdata = {$urandom, $urandom};
            tick();
        end
        bus.burst_resp = 1'b0;
        n_checks++; if (bus.pmem_rdata !== exp_rdata || bus.pmem_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_resp: got rdata %h resp %b required %h 0", bus.pmem_rdata,
                     bus.pmem_resp, exp_rdata); end
        n_checks++; if (bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin n_fail++;
            $display("FAIL idle_resp burst: got %b%b required 00", bus.burst_read,
                     bus.burst_write); end
    endtask

    task automatic test_random();
        logic br, bw, st, wr, rdq;
        logic [31:0] a, addr;
        int rc, gap;
        logic [255:0] rd, ws, line;
        for (int t = 0; t < 12; t++) begin
            wr   = 1'($urandom_range(1, 0));
            rdq  = wr ? 1'($urandom_range(1, 0)) : 1'b1;
            addr = $urandom;
            line = rand256();
            gap  = $urandom_range(3, 0);
            run_txn(rdq, wr, addr, line, gap, 1'b0, br, bw, a, st, rc, rd, ws);
            n_checks++; if (br !== !wr || bw !== wr || st !== 1'b1) begin n_fail++;
                $display("FAIL random[%0d] burst_rw: got %b%b stable %b required %b%b 1", t,
                         br, bw, st, !wr, wr); end
            n_checks++; if (a !== exp_addr(addr)) begin n_fail++;
                $display("FAIL random[%0d] address: got %h required %h", t, a,
                         exp_addr(addr)); end
            n_checks++; if (rc !== 5 + 4 * gap) begin n_fail++;
                $display("FAIL random[%0d] latency: got %0d required %0d", t, rc,
                         5 + 4 * gap); end
            if (wr) begin
                n_checks++; if (ws !== line) begin n_fail++;
                    $display("FAIL random[%0d] wdata: got %h required %h", t, ws, line); end
            end else begin
                n_checks++; if (rd !== line) begin n_fail++;
                    $display("FAIL random[%0d] rdata: got %h required %h", t, rd, line); end
                exp_rdata = line;
            end
            n_checks++; if (bus.pmem_resp !== 1'b0 || bus.pmem_rdata !== exp_rdata) begin
                n_fail++;
                $display("FAIL random[%0d] after: got resp %b rdata %h required 0 %h", t,
                         bus.pmem_resp, bus.pmem_rdata, exp_rdata); end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        exp_rdata = '0;
        rst       = 1'b1;
        test_reset();
        test_read_fixed();
        test_write_gaps();
        test_both();
        test_align();
        test_reset_mid();
        test_hold_read();
        test_idle_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
